// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: two W-bit operands in, W-bit sum plus carry-out back, one shared 1-bit add cell.
// Latency: W cycles from operand accept to out_valid; at most one operation per W+2 cycles.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, with nothing queued meanwhile.
// Optional build macro SERIAL_ADD_SUB_EN: sub=1 computes a - b (cout=1 means no borrow); otherwise sub is ignored.

// Single-bit half adder used twice to form the serial full-add cell.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module serial_add_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic [W-1:0]  w_sum_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic          r_sub;
  logic          w_accept;
  logic          w_last;
  logic          w_b_bit;
  logic          w_init_carry;
  logic          w_s0;
  logic          w_c0;
  logic          w_sum_bit;
  logic          w_c1;
  logic          w_cell_carry;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  // The edge that processes counter value W-1 is the last RUN edge.
  assign w_last   = (r_cnt == CW'(W - 1));

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1: invert B into the cell and seed the carry with 1.
  assign w_b_bit      = r_b[0] ^ r_sub;
  assign w_init_carry = sub;
`else
  logic w_unused_sub;
  assign w_b_bit      = r_b[0];
  assign w_init_carry = 1'b0;
  assign w_unused_sub = r_sub;
`endif

  half_adder u_ha0 (
    .i_a (r_a[0]),
    .i_b (w_b_bit),
    .o_s (w_s0),
    .o_c (w_c0)
  );

  half_adder u_ha1 (
    .i_a (w_s0),
    .i_b (r_carry),
    .o_s (w_sum_bit),
    .o_c (w_c1)
  );

  assign w_cell_carry = w_c0 | w_c1;

  // Sum bits enter at the MSB so that after W shifts bit 0 lands in position 0.
  generate
    if (W == 1) begin : g_sum_w1
      assign w_sum_nxt = w_sum_bit;
    end else begin : g_sum_wn
      assign w_sum_nxt = {w_sum_bit, r_sum[W-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: accept in IDLE, W bit cycles in RUN, hold in DONE until taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decode straight from state.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state == S_RUN) || (r_state == S_DONE);
  end

  // Datapath: load operands on accept, shift one bit per RUN cycle; sum/carry hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sub   <= sub;
      r_cnt   <= '0;
      r_carry <= w_init_carry;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= w_sum_nxt;
      r_carry <= w_cell_carry;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign sum  = r_sum;
  assign cout = r_carry;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: W=8 instance plus a W=1 instance.
// Checks reset values, latency, busy span, back-pressure, ignored inputs, mid-op reset and random operands.
// Expected results come from plain-arithmetic reference model in this file.
module tb_serial_add_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;

  logic       in_valid1;
  logic       in_ready1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       sub1;
  logic       out_valid1;
  logic       out_ready1;
  logic [0:0] sum1;
  logic       cout1;
  logic       busy1;

  int errors = 0;
  int checks = 0;

  serial_add_seq #(.W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_add_seq #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {cout, sum} for an 8-bit operation.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
`ifdef SERIAL_ADD_SUB_EN
    if (s) return {(x >= y), 8'(x - y)};
`endif
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Drive one operation (caller is just after a clock edge with DUT idle), out_ready held high.
  task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xs,
                        output logic [7:0] s_o, output logic c_o, output int lat,
                        output int busy_n, output logic rdy_after);
    out_ready = 1'b1;
    a = xa; b = xb; sub = xs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    lat = 0;
    busy_n = busy ? 1 : 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      busy_n += busy ? 1 : 0;
    end
    s_o = sum; c_o = cout;
    @(posedge clk); #1;
    busy_n += busy ? 1 : 0;
    rdy_after = in_ready;
  endtask

  task automatic test_reset;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready_w1: got %b want 1", in_ready1); end
  endtask

  task automatic test_directed;
    logic [7:0] s; logic c; int lat; int bn; logic r; logic [8:0] e;
    e = model(8'h5A, 8'h3C, 1'b0);
    run_op(8'h5A, 8'h3C, 1'b0, s, c, lat, bn, r);
    checks++; if (s !== e[7:0]) begin errors++; $display("FAIL add_5a_3c_sum: got %h want %h", s, e[7:0]); end
    checks++; if (c !== e[8]) begin errors++; $display("FAIL add_5a_3c_cout: got %b want %b", c, e[8]); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL latency: got %0d want 8", lat); end
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL in_ready_after_handshake: got %b want 1", r); end
    e = model(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, s, c, lat, bn, r);
    checks++; if (s !== e[7:0]) begin errors++; $display("FAIL add_ff_01_sum: got %h want %h", s, e[7:0]); end
    checks++; if (c !== e[8]) begin errors++; $display("FAIL add_ff_01_cout: got %b want %b", c, e[8]); end
    checks++; if (bn !== 9) begin errors++; $display("FAIL busy_span: got %0d want 9", bn); end
  endtask

  task automatic test_sub;
    logic [7:0] s; logic c; int lat; int bn; logic r; logic [8:0] e;
    logic [7:0] va [3] = '{8'h10, 8'h20, 8'h80};
    logic [7:0] vb [3] = '{8'h20, 8'h10, 8'h80};
    for (int i = 0; i < 3; i++) begin
      e = model(va[i], vb[i], 1'b1);
      run_op(va[i], vb[i], 1'b1, s, c, lat, bn, r);
      checks++; if (s !== e[7:0]) begin errors++; $display("FAIL sub_sum[%0d]: got %h want %h", i, s, e[7:0]); end
      checks++; if (c !== e[8]) begin errors++; $display("FAIL sub_cout[%0d]: got %b want %b", i, c, e[8]); end
    end
  endtask

  task automatic test_random;
    logic [7:0] s; logic c; int lat; int bn; logic r; logic [8:0] e;
    logic [7:0] xa; logic [7:0] xb; logic xs;
    for (int i = 0; i < 24; i++) begin
      xa = 8'($urandom); xb = 8'($urandom); xs = 1'($urandom);
      e = model(xa, xb, xs);
      run_op(xa, xb, xs, s, c, lat, bn, r);
      checks++;
      if (s !== e[7:0] || c !== e[8] || lat !== 8) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h sub=%b: got sum=%h cout=%b lat=%0d want sum=%h cout=%b lat=8",
                 i, xa, xb, xs, s, c, lat, e[7:0], e[8]);
      end
    end
  endtask

  task automatic test_back_to_back_pressure;
    logic [8:0] e; int n; int bad;
    e = model(8'h33, 8'h44, 1'b0);
    out_ready = 1'b0;
    a = 8'h33; b = 8'h44; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    a = 8'hAA; b = 8'hAA; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_timeout: got %b want 1", out_valid); end
    a = 8'h01; b = 8'h02; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e[7:0] || cout !== e[8]) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b rdy=%b sum=%h cout=%b want v=1 rdy=0 sum=%h cout=%b",
                 i, out_valid, in_ready, sum, cout, e[7:0], e[8]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ignored_input_queued: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_reset_midop;
    logic [7:0] s; logic c; int lat; int bn; logic r;
    out_ready = 1'b1;
    a = 8'h12; b = 8'h34; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_async_reset: got rdy=%b v=%b sum=%h cout=%b busy=%b want 1 0 00 0 0",
               in_ready, out_valid, sum, cout, busy);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midop_stale_valid: got %b want 0", out_valid); end
    run_op(8'h01, 8'h01, 1'b0, s, c, lat, bn, r);
    checks++;
    if (s !== 8'h02 || c !== 1'b0 || lat !== 8) begin
      errors++; $display("FAIL after_reset_op: got sum=%h cout=%b lat=%0d want 02 0 8", s, c, lat);
    end
  endtask

  task automatic test_w1;
    logic [0:0] xa [2] = '{1'b1, 1'b1};
    logic [0:0] xb [2] = '{1'b1, 1'b0};
    logic [1:0] e;
    int n;
    out_ready1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = {1'b0, xa[i]} + {1'b0, xb[i]};
      a1 = xa[i]; b1 = xb[i]; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      n = 0;
      while (!out_valid1 && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (n !== 1 || sum1 !== e[0] || cout1 !== e[1]) begin
        errors++;
        $display("FAIL w1_op[%0d]: got lat=%0d sum=%b cout=%b want lat=1 sum=%b cout=%b", i, n, sum1, cout1, e[0], e[1]);
      end
      @(posedge clk); #1;
      checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL w1_in_ready[%0d]: got %b want 1", i, in_ready1); end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0; out_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_directed;
    test_sub;
    test_random;
    test_back_to_back_pressure;
    test_reset_midop;
    test_w1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial adder sequencer: accepts two W-bit operands over a valid/ready handshake. It streams them LSB-first through one 1-bit add cell, built from two `half_adder` instances plus an OR for carry, with a registered carry. It returns the W-bit sum and carry-out over a second valid/ready handshake. It sits between an operand producer and a result consumer where area matters more than throughput, and time-shares the single add cell across all W bit positions.

## Interface
- W, default 8, operand/sum width in bits (W >= 1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands a, b (and sub) valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  W  operand A
- b  in  W  operand B
- sub  in  1  subtract request (honoured only with SERIAL_ADD_SUB_EN)
- out_valid  out  1  sum/cout valid
- out_ready  in  1  consumer accepts result
- sum  out  W  result
- cout  out  1  carry out of MSB position
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: in_ready=1. When in_valid && in_ready at a clock edge:
  - capture a and b into shift registers
  - capture sub into a mode flop
  - clear the bit counter to 0
  - load the carry flop with the initial carry (0 for add)
  - go to RUN
- RUN, one bit per cycle:
  - the add cell takes the current LSB of A, the current LSB of B, and the carry flop
  - the sum bit shifts into the MSB of the sum register, which shifts right
  - the carry flop takes the cell carry
  - A and B shift right
  - the counter increments
- On the edge that processes counter value W-1, go to DONE.
- DONE: out_valid=1; sum and cout are stable. On out_valid && out_ready, go to IDLE.
- Inputs are ignored outside IDLE; in_valid during RUN/DONE has no effect and is not queued.
- Arithmetic: sum = (a + b) mod 2^W; cout = bit W of a + b. Counter width is clog2(W+1); it never wraps during a valid operation.
- W=1: RUN lasts exactly one cycle.
- Reset mid-operation, in any state: return immediately to IDLE and clear all registers. The in-flight result is discarded and never presented.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0
  - sum=0
  - cout=0
  - busy=0
- Accept at edge E0. RUN occupies edges E1..EW, and out_valid rises after EW. Latency is W cycles from accept to out_valid.
- Result handshake at edge ED: in_ready=1 from ED onward. The earliest next accept is edge ED+1.
- Throughput: at most one operation per W+2 cycles.
- sum and cout hold their value from DONE entry until the next accept. They are not cleared on leaving DONE.
- The sum/cout outputs are registered; there is no combinational path from inputs to outputs. in_ready and out_valid decode directly from state.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - when sub=1 is captured, the B bits are inverted into the cell and the initial carry is 1
  - the result is sum = (a - b) mod 2^W
  - cout=1 means no borrow (a >= b unsigned)
- SERIAL_ADD_SUB_EN undefined:
  - the sub port still exists but is ignored
  - every operation is an addition with initial carry 0
- All other behaviour and timing are identical in both builds.

## Test plan
- W=8, a=0x5A, b=0x3C, out_ready=1: out_valid rises 8 cycles after accept with sum=0x96, cout=0; in_ready returns 1 the cycle after the result handshake.
- W=8, a=0xFF, b=0x01: sum=0x00, cout=1; busy is high for exactly 9 cycles with out_ready held high.
- Back-pressure: out_ready=0 for 5 cycles in DONE. out_valid stays 1 with sum/cout stable, and in_ready stays 0. A second in_valid pulse during RUN and during DONE is ignored.
- Reset mid-op: accept a=0x12, b=0x34, assert rst after 3 RUN cycles. All outputs go to reset values asynchronously. The next operation a=0x01, b=0x01 yields sum=0x02, cout=0 with no stale result.
- W=1 build: a=1, b=1 gives sum=0, cout=1 one cycle after accept; a=1, b=0 gives sum=1, cout=0.
- SERIAL_ADD_SUB_EN, W=8:
  - sub=1, a=0x10, b=0x20: sum=0xF0, cout=0
  - sub=1, a=0x20, b=0x10: sum=0x10, cout=1
  - without the macro, the same a=0x10, b=0x20 stimulus gives sum=0x30, cout=0
